ghr_index_gen: RTL and testbench
================================

// Module: ghr_index_gen
// PURPOSE
//  Gshare front end for the pattern history table (PHT). Keeps a speculative
//  and a committed global history register (GHR) and forms the PHT read index
//  as PC bits XOR history.
//  Queues each in-flight conditional branch so in-order resolution can write
//  the PHT at the index used for its prediction.
//  Restores history on a mispredict. Sits between fetch PC and the PHT:
//  out_pred_addr drives the PHT read port, out_upd_* drive its write port.
// PARAMETERS
//  PC_WIDTH    64  fetch PC width
//  ADDR_WIDTH  9   PHT index width (512 entries)
//  HIST_WIDTH  9   GHR width; legal range 2..ADDR_WIDTH
//  PC_LSB      2   lowest PC bit used in the index
//  DEPTH       8   in-flight branch queue entries; power of 2
// PORTS
//  in_Clk            in   1           clock, rising edge
//  in_Rst_N          in   1           async active-low reset
//  in_pc             in   PC_WIDTH    fetch PC of current branch
//  in_pred_valid     in   1           conditional branch predicted this cycle
//  in_pred_taken     in   1           PHT prediction for in_pc
//  out_pred_addr     out  ADDR_WIDTH  PHT read index (combinational)
//  out_stall         out  1           queue full; push refused
//  in_res_valid      in   1           oldest in-flight branch resolved
//  in_res_taken      in   1           actual outcome
//  out_upd_en        out  1           PHT write strobe (registered)
//  out_upd_addr      out  ADDR_WIDTH  PHT write index (registered)
//  out_upd_data      out  1           PHT write data = actual outcome
//  out_flush         out  1           mispredict pulse (registered)
//  out_ghr           out  HIST_WIDTH  speculative GHR
//  out_count         out  clog2(DEPTH)+1  queue occupancy
// BEHAVIOUR
//  - Reset (async, any time, including mid-operation): both GHRs, pointers
//    and count clear to 0; out_upd_en, out_upd_addr, out_upd_data and
//    out_flush = 0.
//  - Index: out_pred_addr = in_pc[PC_LSB +: ADDR_WIDTH] ^ zero-extended
//    ghr_spec. Combinational, zero latency.
//  - out_stall = (count == DEPTH), evaluated on the current count. A push
//    while stalled is ignored, even if a resolve pops in the same cycle.
//  - Push (in_pred_valid & !out_stall & !mispredict): enqueue
//    {out_pred_addr, in_pred_taken}; ghr_spec <= {ghr_spec[H-2:0], in_pred_taken}.
//  - Resolve (in_res_valid & count != 0): pop head;
//    ghr_arch <= {ghr_arch[H-2:0], in_res_taken}.
//    Next cycle: out_upd_en = 1, out_upd_addr = head index,
//    out_upd_data = in_res_taken.
//  - in_res_valid with empty queue: ignored; no update, no flush.
//  - Mispredict = resolve & (in_res_taken != head pred_taken):
//    - all younger entries are wrong-path; flush queue, count <= 0;
//    - ghr_spec <= {ghr_arch[H-2:0], in_res_taken}, equal to the new ghr_arch;
//    - out_flush = 1 for one cycle, together with out_upd_en.
//    - A same-cycle push is dropped (mispredict wins).
//  - Push + correct resolve in the same cycle: count unchanged; each GHR
//    shifts once.
//  - Pointers wrap modulo DEPTH. The queue never overflows or underflows.
//  - All registered outputs are 0 in any cycle without a matching event.
// TESTING
//  1. Reset low mid-run with queue at 5 -> out_ghr=0, out_count=0,
//     out_upd_en=0; with in_pc=0x44, out_pred_addr=0x011.
//  2. Push pc=0x44, taken -> out_ghr=0x001; same pc now out_pred_addr=0x010;
//     out_count=1.
//  3. 8 pushes -> out_stall=1; 9th push plus a correct resolve in the same
//     cycle -> push refused, out_count=7, GHR shifted by resolve only.
//  4. Head {0x011, T}, resolve taken -> next cycle out_upd_en=1,
//     out_upd_addr=0x011, out_upd_data=1, out_flush=0, out_count drops by 1.
//  5. From ghr=0, push T,T,T (out_ghr=0x007), resolve not-taken -> next cycle
//     out_flush=1, out_upd_data=0, out_count=0, out_ghr=0x000.
//  6. Push and mispredicting resolve in the same cycle -> push dropped,
//     out_count=0, out_ghr = restored value.

Source files
------------

// File: rtl/ghr_index_gen.sv
// Gshare index generator: speculative/committed global history, PC^GHR PHT index,
// and an in-order queue of in-flight branches that drives PHT updates and mispredict recovery.
module ghr_index_gen #(
    parameter int PC_WIDTH   = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int HIST_WIDTH = 9,
    parameter int PC_LSB     = 2,
    parameter int DEPTH      = 8
) (
    input  logic                       in_Clk,
    input  logic                       in_Rst_N,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic                       in_pred_valid,
    input  logic                       in_pred_taken,
    output logic [ADDR_WIDTH-1:0]      out_pred_addr,
    output logic                       out_stall,
    input  logic                       in_res_valid,
    input  logic                       in_res_taken,
    output logic                       out_upd_en,
    output logic [ADDR_WIDTH-1:0]      out_upd_addr,
    output logic                       out_upd_data,
    output logic                       out_flush,
    output logic [HIST_WIDTH-1:0]      out_ghr,
    output logic [$clog2(DEPTH):0]     out_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [HIST_WIDTH-1:0] ghr_spec;
    logic [HIST_WIDTH-1:0] ghr_arch;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic [ADDR_WIDTH-1:0] q_addr  [DEPTH];
    logic                  q_taken [DEPTH];

    logic                  upd_vld_p1;
    logic [ADDR_WIDTH-1:0] upd_addr_p1;
    logic                  upd_data_p1;
    logic                  flush_p1;

    logic [ADDR_WIDTH-1:0] ghr_ext;
    logic                  res_fire;
    logic                  mispredict;
    logic                  push_fire;
    logic                  unused_pc;

    assign unused_pc     = ^in_pc;
    assign ghr_ext       = ADDR_WIDTH'(ghr_spec);
    assign out_pred_addr = in_pc[PC_LSB +: ADDR_WIDTH] ^ ghr_ext;
    assign out_stall     = (count == CNT_W'(DEPTH));

    // A mispredict squashes everything younger, including a same-cycle push.
    assign res_fire   = in_res_valid && (count != '0);
    assign mispredict = res_fire && (in_res_taken != q_taken[rd_ptr]);
    assign push_fire  = in_pred_valid && !out_stall && !mispredict;

    always_ff @(posedge in_Clk) begin
        if (push_fire) begin
            q_addr[wr_ptr]  <= out_pred_addr;
            q_taken[wr_ptr] <= in_pred_taken;
        end
    end

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            ghr_spec <= '0;
            ghr_arch <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (res_fire)
                ghr_arch <= {ghr_arch[HIST_WIDTH-2:0], in_res_taken};
            if (mispredict) begin
                ghr_spec <= {ghr_arch[HIST_WIDTH-2:0], in_res_taken};
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push_fire) begin
                    ghr_spec <= {ghr_spec[HIST_WIDTH-2:0], in_pred_taken};
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                end
                if (res_fire)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push_fire) - CNT_W'(res_fire);
            end
        end
    end

    // Stage p1: PHT write port and flush, one cycle after resolve.
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            upd_vld_p1  <= 1'b0;
            upd_addr_p1 <= '0;
            upd_data_p1 <= 1'b0;
            flush_p1    <= 1'b0;
        end else begin
            upd_vld_p1  <= res_fire;
            upd_addr_p1 <= res_fire ? q_addr[rd_ptr] : '0;
            upd_data_p1 <= res_fire & in_res_taken;
            flush_p1    <= mispredict;
        end
    end

    assign out_upd_en   = upd_vld_p1;
    assign out_upd_addr = upd_addr_p1;
    assign out_upd_data = upd_data_p1;
    assign out_flush    = flush_p1;
    assign out_ghr      = ghr_spec;
    assign out_count    = count;

endmodule

// File: tb/tb_ghr_index_gen.sv
// Directed bench for ghr_index_gen with hand-computed expectations.
module tb_ghr_index_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc = '0;
    logic        pred_valid = 1'b0;
    logic        pred_taken = 1'b0;
    logic [8:0]  pred_addr;
    logic        stall;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic        upd_en;
    logic [8:0]  upd_addr;
    logic        upd_data;
    logic        flush;
    logic [8:0]  ghr;
    logic [3:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    ghr_index_gen dut (
        .in_Clk(clk), .in_Rst_N(rst_n), .in_pc(pc),
        .in_pred_valid(pred_valid), .in_pred_taken(pred_taken),
        .out_pred_addr(pred_addr), .out_stall(stall),
        .in_res_valid(res_valid), .in_res_taken(res_taken),
        .out_upd_en(upd_en), .out_upd_addr(upd_addr), .out_upd_data(upd_data),
        .out_flush(flush), .out_ghr(ghr), .out_count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then settle 1 time unit past the edge.
    task automatic cyc(input logic [63:0] p, input logic pv, input logic pt,
                       input logic rv, input logic rt);
        pc = p; pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
        @(posedge clk); #1;
        pred_valid = 1'b0; res_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 1: fill to 5, then asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) cyc(64'h44, 1'b1, 1'b1, 1'b0, 1'b0);
        check("fill5_count", count, 5);
        check("fill5_ghr", ghr, 9'h01F);
        #2 rst_n = 1'b0;
        #1;
        pc = 64'h44;
        #1;
        check("rst_ghr", ghr, 0);
        check("rst_count", count, 0);
        check("rst_upd_en", upd_en, 0);
        check("rst_flush", flush, 0);
        check("rst_pred_addr", pred_addr, 9'h011);
        @(posedge clk); #1 rst_n = 1'b1;

        // Test 2: push pc=0x44 taken
        cyc(64'h44, 1'b1, 1'b1, 1'b0, 1'b0);
        check("push_ghr", ghr, 9'h001);
        check("push_pred_addr", pred_addr, 9'h010);
        check("push_count", count, 1);

        // Test 4: head {0x011,T}, correct resolve
        cyc(64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("res_upd_en", upd_en, 1);
        check("res_upd_addr", upd_addr, 9'h011);
        check("res_upd_data", upd_data, 1);
        check("res_flush", flush, 0);
        check("res_count", count, 0);
        check("res_ghr", ghr, 9'h001);
        cyc(64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_upd_en", upd_en, 0);
        check("idle_upd_addr", upd_addr, 0);

        // Test 3: fill to 8, then push while full plus correct resolve
        for (int i = 0; i < 8; i++) cyc(64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("full_stall", stall, 1);
        check("full_count", count, 8);
        check("full_ghr", ghr, 9'h1FF);
        cyc(64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("full_push_count", count, 7);
        check("full_push_ghr", ghr, 9'h1FF);
        check("full_push_stall", stall, 0);
        check("full_upd_en", upd_en, 1);
        check("full_upd_addr", upd_addr, 9'h001);
        for (int i = 0; i < 7; i++) cyc(64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("drain_count", count, 0);

        // Test 5: from ghr=0, push T,T,T then mispredicting resolve
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) cyc(64'h44, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ttt_ghr", ghr, 9'h007);
        check("ttt_count", count, 3);
        cyc(64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("mis_flush", flush, 1);
        check("mis_upd_en", upd_en, 1);
        check("mis_upd_data", upd_data, 0);
        check("mis_upd_addr", upd_addr, 9'h011);
        check("mis_count", count, 0);
        check("mis_ghr", ghr, 9'h000);
        cyc(64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mis_flush_pulse", flush, 0);

        // Resolve on empty queue is ignored
        cyc(64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("empty_upd_en", upd_en, 0);
        check("empty_flush", flush, 0);
        check("empty_count", count, 0);

        // Test 6: push+correct resolve, then push+mispredicting resolve
        cyc(64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(64'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("pr_count", count, 1);
        check("pr_ghr", ghr, 9'h003);
        check("pr_upd_addr", upd_addr, 9'h000);
        cyc(64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("pr2_count", count, 1);
        check("pr2_ghr", ghr, 9'h006);
        cyc(64'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("pm_count", count, 0);
        check("pm_ghr", ghr, 9'h007);
        check("pm_flush", flush, 1);
        check("pm_upd_addr", upd_addr, 9'h003);
        check("pm_upd_data", upd_data, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
